inst_mem_loader: RTL and testbench

//  Boot-time writer for the instruction memory. Consumes a byte stream with a

---
 rtl/loader_pkg.sv | 9 +
 rtl/inst_mem_loader_byte_to_word.sv | 39 +++
 rtl/inst_mem_loader.sv | 95 +++++++++
 tb/tb_inst_mem_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {HDR, LOAD, WRITE, DONE, ERR} loader_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/inst_mem_loader_byte_to_word.sv
// Little-endian byte assembler: a 2-bit byte counter and an LSB-first shift register.
module byte_to_word
  import loader_pkg::*;
#(
  parameter int NBYTES = WORD_BYTES
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam logic [1:0] LAST = 2'(NBYTES - 1);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;

  // o_word already includes the byte in flight, so the word is usable on the accepting edge
  assign o_word      = {i_byte, r_shift[31:8]};
  assign o_word_full = i_push && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!nrst || i_clr) begin
      r_cnt <= '0;
    end else if (i_push) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_shift <= o_word;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory writer: header word count, then N little-endian words.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        start,
  output logic        inst_mem_wren,
  output logic [31:0] inst_mem_write_addr,
  output logic [31:0] inst_mem_write_data,
  output logic        core_run,
  output logic        load_err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  loader_state_t    r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, r_n, w_idx_inc;
  logic [31:0]      r_addr, r_data;
  logic [31:0]      w_word;
  logic             w_full, w_push, w_rearm, w_hdr_bad;

  assign byte_ready = (r_state == HDR) || (r_state == LOAD);
  assign w_push     = byte_valid && byte_ready;
  assign w_rearm    = start && ((r_state == DONE) || (r_state == ERR));
  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_hdr_bad  = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));

  // Header and data words share one assembler; both are four bytes wide.
  byte_to_word #(.NBYTES(HDR_BYTES)) u_b2w (
    .clk         (clk),
    .nrst        (nrst),
    .i_clr       (w_rearm),
    .i_push      (w_push),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HDR:     if (w_full) w_state_nxt = w_hdr_bad ? ERR : LOAD;
      LOAD:    if (w_full) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (w_idx_inc == r_n) ? DONE : LOAD;
      DONE:    if (start) w_state_nxt = HDR;
      ERR:     if (start) w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  // Address and data are captured as the last byte lands so they are valid throughout WRITE
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_idx  <= '0;
      r_n    <= '0;
      r_addr <= BASE_ADDR;
      r_data <= '0;
    end else begin
      if (r_state == HDR && w_full) begin
        r_n <= w_word[IDX_W-1:0];
      end
      if (r_state == LOAD && w_full) begin
        r_addr <= BASE_ADDR + 32'({r_idx, 2'b00});
        r_data <= w_word;
      end
      if (r_state == WRITE) begin
        r_idx <= w_idx_inc;
      end else if (w_rearm) begin
        r_idx <= '0;
      end
    end
  end

  assign inst_mem_wren       = (r_state == WRITE);
  assign inst_mem_write_addr = r_addr;
  assign inst_mem_write_data = r_data;
  assign core_run            = (r_state == DONE);
  assign load_err            = (r_state == ERR);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: drives on negedge, samples on negedge.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        start;
  logic        inst_mem_wren;
  logic [31:0] inst_mem_write_addr;
  logic [31:0] inst_mem_write_data;
  logic        core_run;
  logic        load_err;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr0;

  always #5 clk = ~clk;

  inst_mem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .byte_valid          (byte_valid),
    .byte_data           (byte_data),
    .byte_ready          (byte_ready),
    .start               (start),
    .inst_mem_wren       (inst_mem_wren),
    .inst_mem_write_addr (inst_mem_write_addr),
    .inst_mem_write_data (inst_mem_write_data),
    .core_run            (core_run),
    .load_err            (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every write cycle must also be a not-ready cycle.
  always @(negedge clk) begin
    if (inst_mem_wren === 1'b1) begin
      wr_cnt++;
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int bubbles);
    int guard;
    for (int i = 0; i < bubbles; i++) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 20) begin
      chk("stall_is_write", {31'd0, inst_mem_wren}, 32'd1);
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxbub);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[8*i +: 8], (maxbub > 0) ? int'($urandom_range(0, maxbub)) : 0);
    end
  endtask

  task automatic load_word(input string tag, input logic [31:0] w, input logic [31:0] addr,
                           input int maxbub);
    send_word(w, maxbub);
    chk({tag, "_wren"}, {31'd0, inst_mem_wren}, 32'd1);
    chk({tag, "_addr"}, inst_mem_write_addr, addr);
    chk({tag, "_data"}, inst_mem_write_data, w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_run_at_write"}, {31'd0, core_run}, 32'd0);
    @(negedge clk);
    chk({tag, "_core_run"}, {31'd0, core_run}, 32'd1);
    chk({tag, "_ready_done"}, {31'd0, byte_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    chk({tag, "_wren"},  {31'd0, inst_mem_wren}, 32'd0);
    chk({tag, "_addr"},  inst_mem_write_addr, 32'h0);
    chk({tag, "_data"},  inst_mem_write_data, 32'h0);
    chk({tag, "_run"},   {31'd0, core_run}, 32'd0);
    chk({tag, "_err"},   {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Case 1: two-word image
    wr0 = wr_cnt;
    send_word(32'd2, 0);
    load_word("t1_w0", 32'h0000_0013, 32'h0, 0);
    load_word("t1_w1", 32'h0010_0093, 32'h4, 0);
    check_done("t1");
    chk("t1_wr_count", wr_cnt - wr0, 32'd2);

    // Case 6: re-arm from DONE and load a one-word image
    pulse_start();
    chk("t6_run_cleared", {31'd0, core_run}, 32'd0);
    chk("t6_ready", {31'd0, byte_ready}, 32'd1);
    wr0 = wr_cnt;
    send_word(32'd1, 0);
    load_word("t6_w0", 32'h0000_006F, 32'h0, 0);
    check_done("t6");
    chk("t6_wr_count", wr_cnt - wr0, 32'd1);

    // Case 2: N=0 header
    pulse_start();
    wr0 = wr_cnt;
    send_word(32'd0, 0);
    chk("t2_err", {31'd0, load_err}, 32'd1);
    chk("t2_ready", {31'd0, byte_ready}, 32'd0);
    chk("t2_run", {31'd0, core_run}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_err_hold", {31'd0, load_err}, 32'd1);
    chk("t2_wr_count", wr_cnt - wr0, 32'd0);

    // Case 3: N=MAX_WORDS+1, then recover with start
    pulse_start();
    chk("t3_err_clr", {31'd0, load_err}, 32'd0);
    wr0 = wr_cnt;
    send_word(32'd1025, 0);
    chk("t3_err", {31'd0, load_err}, 32'd1);
    chk("t3_run", {31'd0, core_run}, 32'd0);
    @(negedge clk);
    chk("t3_wr_count", wr_cnt - wr0, 32'd0);
    pulse_start();
    chk("t3_err_clr2", {31'd0, load_err}, 32'd0);
    chk("t3_ready", {31'd0, byte_ready}, 32'd1);

    // Case 4: case 1 with random valid bubbles
    wr0 = wr_cnt;
    send_word(32'd2, 3);
    load_word("t4_w0", 32'h0000_0013, 32'h0, 3);
    load_word("t4_w1", 32'h0010_0093, 32'h4, 3);
    check_done("t4");
    chk("t4_wr_count", wr_cnt - wr0, 32'd2);

    // Case 5: reset in the middle of word 0, then a fresh one-word image
    pulse_start();
    wr0 = wr_cnt;
    send_word(32'd2, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_reset");
    nrst = 1'b1;
    @(negedge clk);
    send_word(32'd1, 0);
    chk("t5_no_partial_wr", wr_cnt - wr0, 32'd0);
    load_word("t5_w0", 32'hDEAD_BEEF, 32'h0, 0);
    check_done("t5");
    chk("t5_wr_count", wr_cnt - wr0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
